corelet_ctrl: RTL
=================

# corelet_ctrl

Job sequencer that drives the corelet from the outside: it issues the 5-bit corelet instruction stream and input-SRAM read addresses, and it collects the corelet's `valid` pulses into output-SRAM write strobes and addresses. One `start` runs one complete tile job:

- weight fetch,
- weight load into the MAC array,
- activation streaming with exec,
- output drain.

The block sits between the top-level testbench/host and the corelet plus its input and output SRAMs.

## Interface
- `row`, 8: MAC array rows; weight words fetched per job.
- `col`, 8: MAC array columns; weight settle cycles after load.
- `addr_w`, 11: SRAM address width.
- `drain_max`, 64: maximum cycles allowed in DRAIN before the job aborts.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs.
- `start`  in  1  job request; sampled only in IDLE.
- `mode_sel`  in  1  latched at start; driven on `inst[2]` for the whole job.
- `w_base`  in  addr_w  input-SRAM address of the first weight word; latched at start.
- `x_base`  in  addr_w  input-SRAM address of the first activation word; latched at start.
- `o_base`  in  addr_w  output-SRAM address for the first result row; latched at start.
- `n_vec`  in  addr_w  number of activation vectors, which equals the number of expected results; latched at start.
- `core_valid`  in  1  corelet `valid`; one pulse per result row.
- `inst`  out  5  instruction bits `{l0_rd, l0_wr, mode, exec, weightload}`.
- `isram_ren`  out  1  input-SRAM read enable; data is available one cycle later.
- `isram_addr`  out  addr_w  input-SRAM read address.
- `osram_wen`  out  1  output-SRAM write enable.
- `osram_addr`  out  addr_w  output-SRAM write address.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse at job end.
- `err`  out  1  sticky drain-timeout flag; cleared by the next accepted start.

## Operation
- All outputs are registered; every output resets to 0. The state is IDLE after reset.
- `inst[2]` equals the latched mode in every non-IDLE state and is 0 in IDLE.
- **IDLE:** on `start` with `n_vec != 0`, latch the inputs, clear `err`, and go to WFETCH. On `start` with `n_vec == 0`, pulse `done` next cycle with no SRAM or inst activity. `start` while busy is ignored.
- **WFETCH (row+1 cycles):**
  - Cycles 0..row-1: `isram_ren = 1`, `isram_addr = w_base + i`.
  - Cycles 1..row: `inst[3]` (l0_wr) = 1, which captures the SRAM data one cycle after each read.
- **WLOAD (row cycles):** `inst[4]` = 1 and `inst[0]` = 1 (l0_rd + weightload).
- **WSETTLE (col cycles):** all inst bits 0 except mode. No SRAM access.
- **XSTREAM (n_vec+2 cycles):**
  - Cycles 0..n_vec-1: `isram_ren = 1`, `isram_addr = x_base + j`.
  - Cycles 1..n_vec: l0_wr = 1.
  - Cycles 2..n_vec+1: `inst[4]` = 1 and `inst[1]` = 1 (l0_rd + exec).
- **DRAIN:** waits until the result count reaches `n_vec`, then goes to FINISH. If `drain_max` cycles elapse in DRAIN first, set `err = 1` and go to FINISH.
- **FINISH (1 cycle):** `done = 1`, then return to IDLE.
- Result capture (XSTREAM and DRAIN only):
  - Each cycle with `core_valid = 1` and count < `n_vec`: `osram_wen = 1` next cycle, `osram_addr = o_base + count`, then count increments.
  - `core_valid` in IDLE/WFETCH/WLOAD/WSETTLE/FINISH, or beyond `n_vec` results, is ignored: no write, no count.
- Address arithmetic is modulo 2^addr_w; `base + offset` wraps silently.
- Reset mid-job returns the block to IDLE immediately: all outputs 0, counters cleared, `err` cleared.

## Timing
- The start-accept edge is E0. The `isram_ren` for `w_base` is registered at E0 and is visible in the cycle after.
- First l0_wr is one cycle after the first `isram_ren`; first weightload follows the last l0_wr of WFETCH directly.
- First exec is exactly 2 cycles after the first activation read.
- `busy` rises at E0 and falls on the edge where FINISH exits. `done` coincides with the last `busy` cycle.
- Write latency: `osram_wen`/`osram_addr` are asserted in the cycle after the `core_valid` cycle.
- Back-to-back `core_valid` produces back-to-back writes with consecutive addresses.
- Minimum job length in cycles: 1 + (row+1) + row + col + (n_vec+2) + DRAIN + 1.

## Test plan
- Nominal job (row=col=8, `w_base=0`, `x_base=16`, `o_base=100`, `n_vec=4`, model corelet returning 4 `core_valid` pulses) -> reads addresses 0..7 then 16..19; 8 weightload cycles; 4 exec cycles starting 2 cycles after the read of 16; writes to 100..103; one `done`; `err = 0`.
- `n_vec = 0` -> `done` one cycle after start; `isram_ren`, `osram_wen` and `inst` stay 0.
- Only 3 of 4 `core_valid` pulses arrive, `drain_max = 64` -> 3 writes (100..102); `done` and `err = 1` after exactly 64 DRAIN cycles; `err` stays high until the next start.
- Extra `core_valid` pulses (6 with `n_vec = 4`), plus a pulse during WLOAD -> exactly 4 writes; stray pulses cause no write.
- Wrap-around: `addr_w = 11`, `x_base = 2046`, `o_base = 2047`, `n_vec = 3` -> reads 2046, 2047, 0; writes 2047, 0, 1.
- `start` asserted during busy, then `reset` pulsed in XSTREAM -> the second start is ignored; all outputs are 0 asynchronously on reset; a fresh start after reset runs a full nominal job.

Source files
------------

// File: rtl/corelet_ctrl.sv
// Tile-job sequencer for the corelet: walks weight fetch, weight load, settle,
// activation streaming and drain, and turns corelet valid pulses into output-SRAM writes.
module corelet_ctrl #(
  parameter int ROW       = 8,
  parameter int COL       = 8,
  parameter int ADDR_W    = 11,
  parameter int DRAIN_MAX = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_mode_sel,
  input  logic [ADDR_W-1:0] i_w_base,
  input  logic [ADDR_W-1:0] i_x_base,
  input  logic [ADDR_W-1:0] i_o_base,
  input  logic [ADDR_W-1:0] i_n_vec,
  input  logic              i_core_valid,
  output logic [4:0]        o_inst,
  output logic              o_isram_ren,
  output logic [ADDR_W-1:0] o_isram_addr,
  output logic              o_osram_wen,
  output logic [ADDR_W-1:0] o_osram_addr,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int CNT_W = ADDR_W + 8;
  localparam logic [CNT_W-1:0]  C_ROW   = CNT_W'(ROW);
  localparam logic [CNT_W-1:0]  C_COL   = CNT_W'(COL);
  localparam logic [CNT_W-1:0]  C_DRAIN = CNT_W'(DRAIN_MAX);
  localparam logic [CNT_W-1:0]  C_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  C_TWO   = CNT_W'(2);
  localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_WFETCH, S_WLOAD, S_WSETTLE, S_XSTREAM, S_DRAIN, S_FINISH
  } state_t;

  state_t            r_state, w_nextState;
  logic [CNT_W-1:0]  r_cnt, w_nextCnt, w_nVecExt;
  logic [ADDR_W-1:0] r_resCnt, r_wBase, r_xBase, r_oBase, r_nVec;
  logic              r_mode;
  logic              w_accept, w_mode, w_resDone, w_timeout, w_capture;
  logic              w_ren, w_l0Rd, w_l0Wr, w_exec, w_wLoad;
  logic [ADDR_W-1:0] w_wBase, w_xBase, w_nVec, w_isramAddr;
  logic [4:0]        w_inst;

  // Outputs are decoded from the next state/count so that every output is a plain register.
  always_comb begin
    w_accept    = (r_state == S_IDLE) && i_start;
    w_mode      = w_accept ? (i_mode_sel && (i_n_vec != '0)) : r_mode;
    w_wBase     = w_accept ? i_w_base : r_wBase;
    w_xBase     = w_accept ? i_x_base : r_xBase;
    w_nVec      = w_accept ? i_n_vec  : r_nVec;
    w_nVecExt   = CNT_W'(w_nVec);
    w_resDone   = (r_resCnt == r_nVec);
    w_timeout   = (r_state == S_DRAIN) && !w_resDone && (r_cnt == C_DRAIN - C_ONE);
    w_capture   = ((r_state == S_XSTREAM) || (r_state == S_DRAIN)) && i_core_valid &&
                  (r_resCnt < r_nVec);
    w_nextState = r_state;
    w_nextCnt   = r_cnt + C_ONE;
    case (r_state)
      S_IDLE: begin
        w_nextCnt = '0;
        if (i_start) w_nextState = (i_n_vec == '0) ? S_FINISH : S_WFETCH;
      end
      S_WFETCH:  if (r_cnt == C_ROW)         begin w_nextState = S_WLOAD;   w_nextCnt = '0; end
      S_WLOAD:   if (r_cnt == C_ROW - C_ONE) begin w_nextState = S_WSETTLE; w_nextCnt = '0; end
      S_WSETTLE: if (r_cnt == C_COL - C_ONE) begin w_nextState = S_XSTREAM; w_nextCnt = '0; end
      S_XSTREAM: if (r_cnt == w_nVecExt + C_ONE) begin w_nextState = S_DRAIN; w_nextCnt = '0; end
      S_DRAIN: begin
        if (w_resDone || (r_cnt == C_DRAIN - C_ONE)) begin
          w_nextState = S_FINISH;
          w_nextCnt   = '0;
        end
      end
      default: begin
        w_nextState = S_IDLE;
        w_nextCnt   = '0;
      end
    endcase

    w_ren       = 1'b0;
    w_l0Wr      = 1'b0;
    w_l0Rd      = 1'b0;
    w_exec      = 1'b0;
    w_wLoad     = 1'b0;
    w_isramAddr = o_isram_addr;
    case (w_nextState)
      S_WFETCH: begin
        w_ren  = w_nextCnt < C_ROW;
        w_l0Wr = w_nextCnt >= C_ONE;
        if (w_ren) w_isramAddr = w_wBase + ADDR_W'(w_nextCnt);
      end
      S_WLOAD: begin
        w_l0Rd  = 1'b1;
        w_wLoad = 1'b1;
      end
      S_XSTREAM: begin
        w_ren  = w_nextCnt < w_nVecExt;
        w_l0Wr = (w_nextCnt >= C_ONE) && (w_nextCnt <= w_nVecExt);
        w_l0Rd = w_nextCnt >= C_TWO;
        w_exec = w_nextCnt >= C_TWO;
        if (w_ren) w_isramAddr = w_xBase + ADDR_W'(w_nextCnt);
      end
      default: ;
    endcase
    w_inst = {w_l0Rd, w_l0Wr, w_mode && (w_nextState != S_IDLE), w_exec, w_wLoad};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_resCnt     <= '0;
      r_mode       <= 1'b0;
      r_wBase      <= '0;
      r_xBase      <= '0;
      r_oBase      <= '0;
      r_nVec       <= '0;
      o_inst       <= '0;
      o_isram_ren  <= 1'b0;
      o_isram_addr <= '0;
      o_osram_wen  <= 1'b0;
      o_osram_addr <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_cnt        <= w_nextCnt;
      o_inst       <= w_inst;
      o_isram_ren  <= w_ren;
      o_isram_addr <= w_isramAddr;
      o_osram_wen  <= w_capture;
      o_busy       <= (w_nextState != S_IDLE);
      o_done       <= (w_nextState == S_FINISH);
      if (w_accept) begin
        r_mode   <= w_mode;
        r_wBase  <= i_w_base;
        r_xBase  <= i_x_base;
        r_oBase  <= i_o_base;
        r_nVec   <= i_n_vec;
        r_resCnt <= '0;
        if (i_n_vec != '0) o_err <= 1'b0;
      end else if (w_timeout) begin
        o_err <= 1'b1;
      end
      // A zero-length job never leaves IDLE-like behaviour, so capture cannot collide with accept.
      if (w_capture) begin
        o_osram_addr <= r_oBase + r_resCnt;
        r_resCnt     <= r_resCnt + A_ONE;
      end
    end
  end

endmodule
